regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WordSize, default 32: data width in bits.
REQ-002 SHALL have parameter NumRegs, default 32: architectural register count; power of two, 2..256.
REQ-003 SHALL have parameter NumRead, default 2: read port count, 1..4.
REQ-004 SHALL have parameter NumWrite, default 1: write port count, 1..3.
REQ-005 SHALL have parameter Bypass, default 1: 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have clk  input  1  clock, all state on the rising edge.
REQ-007 SHALL have nReset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have we  input  NumWrite  per-port write enable.
REQ-009 SHALL have wAddr  input  NumWrite x log2(NumRegs)  per-port write address.
REQ-010 SHALL have wData  input  NumWrite x WordSize  per-port write data.
REQ-011 SHALL have rAddr  input  NumRead x log2(NumRegs)  per-port read address.
REQ-012 SHALL have rData  output  NumRead x WordSize  per-port registered read data.
REQ-013 SHALL have rsvValid  input  1  reserve request: mark rsvAddr as pending-write.
REQ-014 SHALL have rsvAddr  input  log2(NumRegs)  register to reserve.
REQ-015 SHALL have busy  output  NumRegs  registered scoreboard; bit n = register n pending.
REQ-016 SHALL have wConflict  output  1  registered pulse: two or more enabled write ports hit the same non-zero address.

Function
REQ-017 SHALL hardwire register 0: reads return 0, writes to it are discarded, and it is never busy.
REQ-018 SHALL commit wData[p] to register wAddr[p] on the rising edge when we[p]=1 and wAddr[p]!=0.
REQ-019 SHALL, when several enabled ports target one address in the same cycle, commit only the highest-indexed port and assert wConflict on the following cycle for exactly one cycle.
REQ-020 SHALL present rData[r] one cycle after rAddr[r] is sampled (latency 1), for every port independently.
REQ-021 SHALL, with Bypass=1, return the data committed in the same edge when rAddr[r] equals an enabled non-zero wAddr (highest port wins); with Bypass=0, return the pre-write value.
REQ-022 SHALL set busy[rsvAddr] on the edge when rsvValid=1 and rsvAddr!=0.
REQ-023 SHALL clear busy[n] on the edge in which any enabled write port commits to n.
REQ-024 SHALL keep busy[n] set when a reserve and a write to n occur in the same cycle (the reserve wins, representing a newer pending writer).
REQ-025 SHALL accept a reserve to an already-busy register as a no-op (busy stays 1); no count of pending writers is kept.
REQ-026 SHALL leave busy bits of registers not written or reserved unchanged.
REQ-027 SHALL treat reads of busy registers normally; stalling is the consumer's responsibility.

Reset
REQ-028 SHALL, on nReset low, asynchronously clear all registers, all rData, busy, and wConflict to 0, regardless of in-flight writes or reserves.
REQ-029 SHALL ignore we and rsvValid while nReset is low and begin normal operation on the first rising edge after deassertion.

Structure
REQ-030 SHALL take the address-width function, the busy-vector typedef, and the zero-register constant from a shared package regfile_pkg.
REQ-031 SHALL implement scoreboard logic (REQ-022..REQ-026) in sub-module regfile_scoreboard, instantiated once.
REQ-032 SHALL implement storage as NumRegs-1 flops (index 1..NumRegs-1); no memory macros.

Verification
REQ-033 SHALL cover: reset, write r5=0xDEADBEEF, read r5 next cycle -> rData=0xDEADBEEF one cycle after the read address is sampled.
REQ-034 SHALL cover: we on both ports, wAddr=7, wData 0x11 and 0x22 -> r7=0x22, with wConflict high for exactly one cycle.
REQ-035 SHALL cover: same-cycle write r3=0xA5 and read r3, with r3 previously 0x5A -> rData=0xA5 if Bypass=1, 0x5A if Bypass=0.
REQ-036 SHALL cover: write r0=0xFFFFFFFF and reserve r0, then read r0 -> rData=0 and busy[0]=0.
REQ-037 SHALL cover: reserve r9, then a write to r9 with a simultaneous reserve of r9 -> busy[9] stays 1; a later lone write to r9 -> busy[9]=0.
REQ-038 SHALL cover: assert nReset mid-burst with r4 busy and holding 0x1234 -> r4 reads 0 and busy is all zero after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file.
// Provides the address-width helper, the scoreboard flag type and the
// hardwired zero-register index.
package regfile_pkg;

   // Hardwired-zero architectural register
   localparam int unsigned ZERO_REG = 0;

   // One scoreboard flag. The busy vector is a packed array of these,
   // sized by the instantiating module.
   typedef logic busy_flag_t;

   // Address width needed to index n registers (n is a power of two >= 2)
   function automatic int unsigned addr_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for regfile_mp.
// Ports: clk/nReset; we/wAddr (write ports, commit clears busy);
// rsvValid/rsvAddr (reserve sets busy); busy (registered, bit n = reg n pending).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NumRegs  = 32,
   parameter int unsigned NumWrite = 1
) (
   input  logic                                       clk,
   input  logic                                       nReset,
   input  logic [NumWrite-1:0]                        we,
   input  logic [NumWrite-1:0][addr_w(NumRegs)-1:0]   wAddr,
   input  logic                                       rsvValid,
   input  logic [addr_w(NumRegs)-1:0]                 rsvAddr,
   output busy_flag_t [NumRegs-1:0]                   busy
);

   localparam int unsigned AW = addr_w(NumRegs);

   busy_flag_t [NumRegs-1:0] busy_d;
   busy_flag_t [NumRegs-1:0] busy_q;

   // Commit clears, reserve sets afterwards so a same-cycle reserve wins
   always_comb begin
      busy_d = busy_q;
      for (int unsigned n = 1; n < NumRegs; n++) begin
         for (int unsigned p = 0; p < NumWrite; p++) begin
            if (we[p] && (wAddr[p] == AW'(n))) begin
               busy_d[n] = 1'b0;
            end
         end
         if (rsvValid && (rsvAddr == AW'(n))) begin
            busy_d[n] = 1'b1;
         end
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with hardwired r0, registered reads,
// optional write-to-read bypass and a pending-write scoreboard.
// Ports: clk/nReset; we/wAddr/wData (NumWrite write ports);
// rAddr/rData (NumRead read ports, latency 1); rsvValid/rsvAddr (reserve);
// busy (scoreboard); wConflict (pulse on same-address multi-port write).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned WordSize = 32,
   parameter int unsigned NumRegs  = 32,
   parameter int unsigned NumRead  = 2,
   parameter int unsigned NumWrite = 1,
   parameter bit          Bypass   = 1'b1
) (
   input  logic                                       clk,
   input  logic                                       nReset,
   input  logic [NumWrite-1:0]                        we,
   input  logic [NumWrite-1:0][addr_w(NumRegs)-1:0]   wAddr,
   input  logic [NumWrite-1:0][WordSize-1:0]          wData,
   input  logic [NumRead-1:0][addr_w(NumRegs)-1:0]    rAddr,
   output logic [NumRead-1:0][WordSize-1:0]           rData,
   input  logic                                       rsvValid,
   input  logic [addr_w(NumRegs)-1:0]                 rsvAddr,
   output busy_flag_t [NumRegs-1:0]                   busy,
   output logic                                       wConflict
);

   localparam int unsigned AW = addr_w(NumRegs);

   logic [WordSize-1:0]                 regs_d [NumRegs-1:1];
   logic [WordSize-1:0]                 regs_q [NumRegs-1:1];
   logic [NumRead-1:0][WordSize-1:0]    rdata_d;
   logic [NumRead-1:0][WordSize-1:0]    rdata_q;
   logic                                wconflict_d;
   logic                                wconflict_q;

   // Write commit: ascending port order so the highest-indexed port wins
   always_comb begin
      for (int unsigned n = 1; n < NumRegs; n++) begin
         regs_d[n] = regs_q[n];
         for (int unsigned p = 0; p < NumWrite; p++) begin
            if (we[p] && (wAddr[p] == AW'(n))) begin
               regs_d[n] = wData[p];
            end
         end
      end
   end

   // Read mux: r0 reads as zero; bypass selects post-commit values
   always_comb begin
      rdata_d = '0;
      for (int unsigned r = 0; r < NumRead; r++) begin
         for (int unsigned n = 1; n < NumRegs; n++) begin
            if (rAddr[r] == AW'(n)) begin
               rdata_d[r] = Bypass ? regs_d[n] : regs_q[n];
            end
         end
      end
   end

   // Conflict: any two enabled ports on the same non-zero address
   always_comb begin
      wconflict_d = 1'b0;
      for (int unsigned p = 0; p < NumWrite; p++) begin
         for (int unsigned q = p + 1; q < NumWrite; q++) begin
            if (we[p] && we[q] && (wAddr[p] == wAddr[q]) &&
                (wAddr[p] != AW'(ZERO_REG))) begin
               wconflict_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned n = 1; n < NumRegs; n++) begin
            regs_q[n] <= '0;
         end
         rdata_q     <= '0;
         wconflict_q <= 1'b0;
      end else begin
         for (int unsigned n = 1; n < NumRegs; n++) begin
            regs_q[n] <= regs_d[n];
         end
         rdata_q     <= rdata_d;
         wconflict_q <= wconflict_d;
      end
   end

   assign rData     = rdata_q;
   assign wConflict = wconflict_q;

   regfile_scoreboard #(
      .NumRegs  (NumRegs),
      .NumWrite (NumWrite)
   ) u_scoreboard (
      .clk      (clk),
      .nReset   (nReset),
      .we       (we),
      .wAddr    (wAddr),
      .rsvValid (rsvValid),
      .rsvAddr  (rsvAddr),
      .busy     (busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: a bypassing and a non-bypassing
// instance share all inputs (two write ports, two read ports).
module tb_regfile_mp;

   localparam int unsigned W  = 32;
   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;

   logic                 clk = 1'b0;
   logic                 nReset;
   logic [1:0]           we;
   logic [1:0][AW-1:0]   wAddr;
   logic [1:0][W-1:0]    wData;
   logic [1:0][AW-1:0]   rAddr;
   logic                 rsvValid;
   logic [AW-1:0]        rsvAddr;
   logic [1:0][W-1:0]    rdata_a, rdata_b;
   logic [NR-1:0]        busy_a, busy_b;
   logic                 wconf_a, wconf_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_mp #(.WordSize(W), .NumRegs(NR), .NumRead(2), .NumWrite(2), .Bypass(1'b1)) u_dut (
      .clk(clk), .nReset(nReset), .we(we), .wAddr(wAddr), .wData(wData),
      .rAddr(rAddr), .rData(rdata_a), .rsvValid(rsvValid), .rsvAddr(rsvAddr),
      .busy(busy_a), .wConflict(wconf_a));

   regfile_mp #(.WordSize(W), .NumRegs(NR), .NumRead(2), .NumWrite(2), .Bypass(1'b0)) u_dut_nb (
      .clk(clk), .nReset(nReset), .we(we), .wAddr(wAddr), .wData(wData),
      .rAddr(rAddr), .rData(rdata_b), .rsvValid(rsvValid), .rsvAddr(rsvAddr),
      .busy(busy_b), .wConflict(wconf_b));

   task automatic idle();
      we = '0; wAddr = '0; wData = '0; rAddr = '0; rsvValid = 1'b0; rsvAddr = '0;
   endtask

   // Inputs change at negedge; outputs are checked at the following negedge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      idle();
      we = 2'b11; wAddr[0] = 5'd2; wData[0] = 32'hFFFF_0000; rsvValid = 1'b1; rsvAddr = 5'd2;
      repeat (3) step();
      checks++; if (rdata_a !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
      checks++; if (busy_a !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_a); end
      checks++; if (wconf_a !== 1'b0) begin errors++; $display("FAIL reset_wconflict: got %b expected 0", wconf_a); end
      idle();
      nReset = 1'b1;
      rAddr[0] = 5'd2;
      step();
      checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL reset_write_ignored: got %h expected 0", rdata_a[0]); end
   endtask

   task automatic test_write_read();
      idle();
      we[0] = 1'b1; wAddr[0] = 5'd5; wData[0] = 32'hDEAD_BEEF;
      step();
      idle();
      rAddr[0] = 5'd5;
      #1;
      checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL read_latency: got %h expected 0", rdata_a[0]); end
      step();
      checks++; if (rdata_a[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_r5: got %h expected deadbeef", rdata_a[0]); end
      checks++; if (rdata_b[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_r5_nb: got %h expected deadbeef", rdata_b[0]); end
      checks++; if (rdata_a[1] !== 32'h0) begin errors++; $display("FAIL read_port1_r0: got %h expected 0", rdata_a[1]); end
   endtask

   task automatic test_conflict();
      idle();
      we = 2'b11; wAddr[0] = 5'd7; wAddr[1] = 5'd7; wData[0] = 32'h11; wData[1] = 32'h22;
      step();
      checks++; if (wconf_a !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b expected 1", wconf_a); end
      idle();
      rAddr[1] = 5'd7;
      step();
      checks++; if (wconf_a !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle: got %b expected 0", wconf_a); end
      checks++; if (rdata_a[1] !== 32'h22) begin errors++; $display("FAIL conflict_r7: got %h expected 22", rdata_a[1]); end
      // distinct addresses: both commit, no conflict
      we = 2'b11; wAddr[0] = 5'd8; wAddr[1] = 5'd10; wData[0] = 32'h88; wData[1] = 32'hAA;
      rAddr = '0;
      step();
      checks++; if (wconf_a !== 1'b0) begin errors++; $display("FAIL conflict_distinct: got %b expected 0", wconf_a); end
      idle();
      rAddr[0] = 5'd8; rAddr[1] = 5'd10;
      step();
      checks++; if (rdata_a !== {32'hAA, 32'h88}) begin errors++; $display("FAIL dual_write: got %h expected 000000aa00000088", rdata_a); end
      // both ports on r0: not a conflict
      we = 2'b11; wAddr = '0; wData[0] = 32'h1; wData[1] = 32'h2;
      step();
      checks++; if (wconf_a !== 1'b0) begin errors++; $display("FAIL conflict_r0: got %b expected 0", wconf_a); end
      idle();
   endtask

   task automatic test_bypass();
      idle();
      we[0] = 1'b1; wAddr[0] = 5'd3; wData[0] = 32'h5A;
      step();
      we[0] = 1'b1; wAddr[0] = 5'd3; wData[0] = 32'hA5; rAddr[0] = 5'd3;
      step();
      checks++; if (rdata_a[0] !== 32'hA5) begin errors++; $display("FAIL bypass_on: got %h expected a5", rdata_a[0]); end
      checks++; if (rdata_b[0] !== 32'h5A) begin errors++; $display("FAIL bypass_off: got %h expected 5a", rdata_b[0]); end
      idle();
      rAddr[0] = 5'd3;
      step();
      checks++; if (rdata_b[0] !== 32'hA5) begin errors++; $display("FAIL bypass_off_next: got %h expected a5", rdata_b[0]); end
      // two ports on r11 with bypass read: highest port's data forwarded
      we = 2'b11; wAddr[0] = 5'd11; wAddr[1] = 5'd11; wData[0] = 32'h0B0; wData[1] = 32'h0B1; rAddr[1] = 5'd11;
      step();
      checks++; if (rdata_a[1] !== 32'h0B1) begin errors++; $display("FAIL bypass_high_port: got %h expected b1", rdata_a[1]); end
      idle();
   endtask

   task automatic test_zero();
      idle();
      we[0] = 1'b1; wAddr[0] = 5'd0; wData[0] = 32'hFFFF_FFFF;
      rsvValid = 1'b1; rsvAddr = 5'd0; rAddr[0] = 5'd0;
      step();
      checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h expected 0", rdata_a[0]); end
      checks++; if (busy_a !== '0) begin errors++; $display("FAIL r0_busy: got %h expected 0", busy_a); end
      idle();
      rAddr[0] = 5'd0;
      step();
      checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL r0_read: got %h expected 0", rdata_a[0]); end
   endtask

   task automatic test_reserve();
      idle();
      rsvValid = 1'b1; rsvAddr = 5'd9;
      step();
      checks++; if (busy_a !== 32'h0000_0200) begin errors++; $display("FAIL rsv_set: got %h expected 00000200", busy_a); end
      // reserve again: no-op, plus write+reserve same cycle keeps it
      we[0] = 1'b1; wAddr[0] = 5'd9; wData[0] = 32'h99;
      step();
      checks++; if (busy_a !== 32'h0000_0200) begin errors++; $display("FAIL rsv_wins: got %h expected 00000200", busy_a); end
      idle();
      we[1] = 1'b1; wAddr[1] = 5'd9; wData[1] = 32'h9A;
      step();
      checks++; if (busy_a !== 32'h0) begin errors++; $display("FAIL rsv_clear: got %h expected 0", busy_a); end
      // reserve r12 while writing r13: independent bits
      idle();
      rsvValid = 1'b1; rsvAddr = 5'd12; we[0] = 1'b1; wAddr[0] = 5'd13; wData[0] = 32'h13;
      step();
      checks++; if (busy_b !== 32'h0000_1000) begin errors++; $display("FAIL rsv_indep: got %h expected 00001000", busy_b); end
      idle();
      we[0] = 1'b1; wAddr[0] = 5'd12; wData[0] = 32'h12;
      step();
      idle();
   endtask

   task automatic test_reset_midburst();
      idle();
      we[0] = 1'b1; wAddr[0] = 5'd4; wData[0] = 32'h1234;
      step();
      idle();
      rsvValid = 1'b1; rsvAddr = 5'd4; rAddr[0] = 5'd4;
      step();
      checks++; if (busy_a !== 32'h0000_0010) begin errors++; $display("FAIL pre_reset_busy: got %h expected 00000010", busy_a); end
      checks++; if (rdata_a[0] !== 32'h1234) begin errors++; $display("FAIL pre_reset_r4: got %h expected 1234", rdata_a[0]); end
      idle();
      we = 2'b11; wAddr[0] = 5'd6; wAddr[1] = 5'd6; wData[0] = 32'h66; wData[1] = 32'h67;
      rsvValid = 1'b1; rsvAddr = 5'd6; rAddr[0] = 5'd4;
      #2 nReset = 1'b0;
      #1;
      checks++; if (busy_a !== '0 || rdata_a !== '0) begin errors++; $display("FAIL async_reset: busy %h rdata %h expected 0", busy_a, rdata_a); end
      repeat (2) step();
      checks++; if (wconf_a !== 1'b0 || busy_a !== '0) begin errors++; $display("FAIL reset_hold: wconf %b busy %h expected 0", wconf_a, busy_a); end
      idle();
      nReset = 1'b1;
      rAddr[0] = 5'd4; rAddr[1] = 5'd6;
      step();
      checks++; if (rdata_a !== '0) begin errors++; $display("FAIL post_reset_read: got %h expected 0", rdata_a); end
      checks++; if (busy_a !== '0) begin errors++; $display("FAIL post_reset_busy: got %h expected 0", busy_a); end
      checks++; if (rdata_b !== '0) begin errors++; $display("FAIL post_reset_read_nb: got %h expected 0", rdata_b); end
   endtask

   initial begin
      nReset = 1'b0;
      idle();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_conflict();
      test_bypass();
      test_zero();
      test_reserve();
      test_reset_midburst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
